// File: rtl/multicycle_seq_ctrl_if.sv
// Shared instruction/data memory port of the multi-cycle RV32I core.
//   mem_req   : access request (controller -> memory)
//   mem_we    : store strobe, qualifies mem_req
//   addr_sel  : address mux select, 0 = PC, 1 = ALU result
//   mem_ready : completion of the current request (memory -> controller)
interface multicycle_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// Sequencing controller for the multi-cycle RV32I core. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port, drives the datapath strobes and
// selects, counts retired instructions and traps on illegal opcodes or memory timeouts.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   mem            : memory handshake (master side)
//   opcode_i       : IR[6:0], stable from DECODE to the end of the instruction
//   br_taken_i     : branch-compare result, valid in EXEC
//   ir_we_o        : latch IR
//   pc_we_o        : update PC; pc_src_o 0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
//   rf_we_o        : register-file write; wb_sel_o 0=ALU, 1=mem data, 2=PC+4
//   alu_a_sel_o    : ALU operand A, 0=rs1, 1=PC
//   state_o        : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   trap_o         : sticky trap flag; trap_cause_o 0=none, 1=illegal, 2=mem timeout
//   instret_o      : retired-instruction counter (wraps)
module multicycle_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_seq_ctrl_if.master mem,
  input  logic [6:0]            opcode_i,
  input  logic                  br_taken_i,
  output logic                  ir_we_o,
  output logic                  pc_we_o,
  output logic [1:0]            pc_src_o,
  output logic                  rf_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  alu_a_sel_o,
  output logic [2:0]            state_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
  output logic [CNT_W-1:0]      instret_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  // Wait count at which a still-unready access has used up its budget.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Opcode classes
  logic op_r, op_i, op_load, op_store, op_branch, op_jal, op_jalr, op_lui, op_auipc, op_legal;
  assign op_r      = (opcode_i == 7'b0110011);
  assign op_i      = (opcode_i == 7'b0010011);
  assign op_load   = (opcode_i == 7'b0000011);
  assign op_store  = (opcode_i == 7'b0100011);
  assign op_branch = (opcode_i == 7'b1100011);
  assign op_jal    = (opcode_i == 7'b1101111);
  assign op_jalr   = (opcode_i == 7'b1100111);
  assign op_lui    = (opcode_i == 7'b0110111);
  assign op_auipc  = (opcode_i == 7'b0010111);
  assign op_legal  = op_r | op_i | op_load | op_store | op_branch | op_jal | op_jalr |
                     op_lui | op_auipc;

  // Timeout fires on the MEM_TIMEOUT-th unready cycle; a ready in that cycle still wins.
  logic in_access, timeout;
  assign in_access = (state_q == StFetch) || (state_q == StMem);
  assign timeout   = in_access && !mem.mem_ready && (wait_q == WaitLast);
  assign wait_d    = (in_access && !mem.mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      wait_q    <= 8'd0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      StFetch: begin
        if (mem.mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end
      end
      StDecode: begin
        if (op_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end
      end
      StExec: begin
        if (op_load || op_store) state_d = StMem;
        else if (op_branch)      state_d = StFetch;
        else                     state_d = StWb;
      end
      StMem: begin
        if (mem.mem_ready) begin
          state_d = op_load ? StWb : StFetch;
        end else if (timeout) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Output logic; everything is held low while reset is asserted.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 2'd0;
    rf_we_o      = 1'b0;
    wb_sel_o     = 2'd0;
    alu_a_sel_o  = 1'b0;
    retire       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        StFetch: begin
          mem.mem_req = 1'b1;
          ir_we_o     = mem.mem_ready;
        end
        StExec: begin
          alu_a_sel_o = op_auipc;
          if (op_branch) begin
            pc_we_o  = 1'b1;
            pc_src_o = br_taken_i ? 2'd1 : 2'd0;
            retire   = 1'b1;
          end
        end
        StMem: begin
          mem.mem_req  = 1'b1;
          mem.addr_sel = 1'b1;
          mem.mem_we   = op_store;
          if (op_store && mem.mem_ready) begin
            pc_we_o = 1'b1;
            retire  = 1'b1;
          end
        end
        StWb: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          retire   = 1'b1;
          wb_sel_o = op_load ? 2'd1 : ((op_jal || op_jalr) ? 2'd2 : 2'd0);
          pc_src_o = op_jal ? 2'd1 : (op_jalr ? 2'd2 : 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign instret_d    = instret_q + {{(CNT_W-1){1'b0}}, retire};
  assign state_o      = state_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule
